// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with whole-line refill.
// Optional hit/miss performance counters are built when ICACHE_PERF_EN is defined;
// otherwise hit_cnt/miss_cnt are tied to zero and no counter flops exist.
module icache #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_flag,
  input  logic [31:0] addr,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
  localparam logic [OFF_W-1:0] BEAT_ONE  = OFF_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;

  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [31:0]       r_data [SETS][LINE_WORDS];

  logic [29:0]       r_req_word;
  logic [OFF_W-1:0]  r_beat;
  logic [31:0]       r_read_data;
  logic              r_busy;
  logic              r_done;
  logic              r_mem_read;
  logic [31:0]       r_mem_addr;

  logic [OFF_W-1:0]  w_in_off;
  logic [IDX_W-1:0]  w_in_idx;
  logic [TAG_W-1:0]  w_in_tag;
  logic              w_hit;
  logic [OFF_W-1:0]  w_req_off;
  logic [IDX_W-1:0]  w_req_idx;
  logic [TAG_W-1:0]  w_req_tag;
  logic [OFF_W-1:0]  w_beat_inc;
  logic              w_last_beat;
  logic              w_unused;

  // Byte-offset bits of the fetch address never matter.
  assign w_unused = &{1'b0, addr[1:0]};

  assign w_in_off  = addr[2 +: OFF_W];
  assign w_in_idx  = addr[OFF_W+2 +: IDX_W];
  assign w_in_tag  = addr[31 -: TAG_W];
  assign w_hit     = r_valid[w_in_idx] && (r_tag[w_in_idx] == w_in_tag);

  assign w_req_off = r_req_word[OFF_W-1:0];
  assign w_req_idx = r_req_word[OFF_W +: IDX_W];
  assign w_req_tag = r_req_word[29 -: TAG_W];

  assign w_beat_inc  = r_beat + BEAT_ONE;
  assign w_last_beat = mem_valid && (r_beat == LAST_BEAT);

  assign read_data = r_read_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_read  = r_mem_read;
  assign mem_addr  = r_mem_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic: a hit answers directly, a miss refills, DONE lasts one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (read_flag) w_next = w_hit ? S_DONE : S_REFILL;
      S_REFILL: if (w_last_beat) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Control and response registers; valid bits live here so reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_read_data <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_addr  <= '0;
      r_beat      <= '0;
      r_valid     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (read_flag) begin
            r_req_word <= addr[31:2];
            if (w_hit) begin
              r_read_data <= r_data[w_in_idx][w_in_off];
              r_done      <= 1'b1;
            end else begin
              // The victim line is dropped now so a partial refill can never look valid.
              r_valid[w_in_idx] <= 1'b0;
              r_busy            <= 1'b1;
              r_beat            <= '0;
              r_mem_read        <= 1'b1;
              r_mem_addr        <= {addr[31:OFF_W+2], {OFF_W{1'b0}}, 2'b00};
            end
          end
        end
        S_REFILL: begin
          if (mem_valid) begin
            if (r_beat == LAST_BEAT) begin
              r_valid[w_req_idx] <= 1'b1;
              // The requested word may be the one arriving right now.
              r_read_data <= (w_req_off == LAST_BEAT) ? mem_rdata
                                                      : r_data[w_req_idx][w_req_off];
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_mem_read  <= 1'b0;
              r_beat      <= '0;
            end else begin
              r_beat     <= w_beat_inc;
              r_mem_addr <= {r_req_word[29:OFF_W], w_beat_inc, 2'b00};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage: each refill beat writes one word; the tag lands with the last beat.
  always_ff @(posedge clk) begin
    if (r_state == S_REFILL && mem_valid) begin
      r_data[w_req_idx][r_beat] <= mem_rdata;
      if (r_beat == LAST_BEAT) r_tag[w_req_idx] <= w_req_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Count every accepted lookup as a hit or a miss; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_IDLE && read_flag) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the instruction fetch stage and the instruction memory bus. It serves fetch requests over the fetch-side `if_icache_inf` signals `read_flag`, `addr`, `read_data`, `busy` and `done`. On a miss it refills a whole line from memory, one word per beat, and then returns the requested word. The fetch stage treats `busy` as a stall source and takes the instruction only in the cycle `done` is high.

## Interface
- `LINE_WORDS`, 4: 32-bit words per line; power of two, ≥2.
- `SETS`, 64: number of lines; power of two.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `read_flag`  in  1  fetch request; sampled only in IDLE.
- `addr`  in  32  fetch byte address; `addr[1:0]` ignored.
- `read_data`  out  32  instruction word; valid only while `done`=1.
- `busy`  out  1  a miss refill is in progress.
- `done`  out  1  one-cycle response strobe.
- `mem_read`  out  1  refill request level.
- `mem_addr`  out  32  word-aligned refill address.
- `mem_rdata`  in  32  refill data.
- `mem_valid`  in  1  `mem_rdata` valid this cycle; one word per assertion.
- `hit_cnt`  out  32  hit counter; see Configuration.
- `miss_cnt`  out  32  miss counter; see Configuration.

## Operation
**Address split**
- offset = `addr[log2(LINE_WORDS)+1:2]`
- index = next `log2(SETS)` bits
- tag = remaining upper bits
- Storage per set: valid bit, tag, and LINE_WORDS data words. Arrays are reg-based with combinational read.

**FSM states: IDLE, REFILL, DONE**
- IDLE
  - `read_flag`=1: latch `addr` into `req_addr`.
  - Hit (valid and tag match): register the data word into `read_data`, set `done`, go to DONE.
  - Miss: set `busy`, clear the beat counter, go to REFILL.
- REFILL
  - `mem_read`=1.
  - `mem_addr` = {`req_addr` line base} + beat×4. Beats run 0..LINE_WORDS-1 in order.
  - Each `mem_valid` writes `mem_rdata` into data[index][beat] and increments beat.
  - When `mem_valid` arrives on the last beat: write the tag, set valid, load `read_data` with the word at the request offset (taking `mem_rdata` directly if that word arrives on the last beat), clear `busy`, set `done`, go to DONE.
- DONE
  - `done`=1 for exactly this cycle.
  - `read_flag` is ignored.
  - Next state is IDLE.

**Output rules**
- `busy` and `done` are never high together.
- `read_data` holds its value outside `done`; no consumer may rely on it then.
- `mem_rdata` is ignored whenever `mem_valid`=0 or the state is not REFILL.
- A line never becomes valid until all LINE_WORDS beats have arrived.

## Timing
- **Reset values:** `read_data`=0, `busy`=0, `done`=0, `mem_read`=0, `mem_addr`=0, `hit_cnt`=0, `miss_cnt`=0, all valid bits=0, FSM=IDLE, beat=0.
- **Hit:** `read_flag` in cycle N → `done`=1 in N+1. Peak throughput is one fetch every 2 cycles, because the fetch stage re-requests only after `done` falls.
- **Miss:**
  - `read_flag` in cycle N → `busy`=1 from N+1 through the cycle of the last `mem_valid`.
  - `done` is high the cycle after the last `mem_valid`.
  - `mem_read` rises in N+1.
  - `mem_read` and `mem_addr` are registered.
  - `mem_addr` advances the cycle after each `mem_valid`.
  - `mem_valid` may arrive no earlier than the cycle after `mem_read` rises.
  - Minimum miss latency: LINE_WORDS+2 cycles from `read_flag` to `done`.
- **Reset mid-refill:** the refill aborts, `mem_read` drops in the next cycle, the partial line stays invalid, and no `done` is issued.
- **`read_flag` with `addr` changing during REFILL:** ignored; the latched `req_addr` governs.
- **Two consecutive misses to the same index:** the second evicts the first unconditionally; there is no replacement choice.
- **Tag compare:** uses the full upper-bit tag. `addr`=0 is not special.

## Configuration
- Macro: `ICACHE_PERF_EN`.
- **Defined:**
  - `hit_cnt` increments on every IDLE hit.
  - `miss_cnt` increments on every IDLE miss, in the cycle after acceptance.
  - Both are 32-bit, wrap 0xFFFFFFFF→0, and are cleared by reset.
- **Undefined:** `hit_cnt` and `miss_cnt` are tied to 0 and no counter flops are built. Port list is unchanged.

## Test plan
1. **Reset:** hold `rst`=0 for 3 cycles → all outputs 0. Then read 0x0000_0010 → miss (`busy`=1), proving valid bits were cleared.
2. **Cold miss, then hit:**
   - Read 0x0000_0104 with memory returning 0xA0+i for word i and 1-cycle `mem_valid` latency → `mem_addr` runs 0x100, 0x104, 0x108, 0x10C; `done` carries 0xA1; `miss_cnt`=1.
   - Re-read 0x0000_0108 → `done` at N+1 with 0xA2; `hit_cnt`=1.
3. **Conflict eviction (SETS=64, line 16 B):**
   - Fill 0x0000_0000, then read 0x0000_0400 (same index, different tag) → miss and refill.
   - Read 0x0000_0000 again → miss.
4. **Stalled memory:** insert 5 idle cycles between each `mem_valid` → `busy` stays high throughout, `mem_addr` holds between beats, `done` occurs exactly once.
5. **Reset mid-refill:** assert `rst`=0 after beat 2 of a refill of 0x200.
   - `mem_read`=0 the next cycle.
   - A following read of 0x200 misses again.
   - Data returned afterwards matches the new memory contents.
6. **Config build:** build without `ICACHE_PERF_EN` and run scenario 2 → `hit_cnt`=`miss_cnt`=0. With the macro defined, force `hit_cnt` to 0xFFFFFFFF and hit once → 0.
